// File: rtl/seg_pkg.sv
// Shared types and segment constants for the 7-segment scan driver.
// Patterns are {a,b,c,d,e,f,g,dp}, active-high.
package seg_pkg;

    typedef enum logic {
        BLANK,
        DRIVE
    } scan_state_t;

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_ERR   = 8'h01;
    localparam logic [7:0] SEG_ZERO  = 8'hFC;
    localparam logic [7:0] SEG_ONE   = 8'h60;
    localparam logic [7:0] SEG_TWO   = 8'hDA;
    localparam logic [7:0] SEG_THREE = 8'hF2;
    localparam logic [7:0] SEG_FOUR  = 8'h66;
    localparam logic [7:0] SEG_FIVE  = 8'hB6;
    localparam logic [7:0] SEG_SIX   = 8'hBE;
    localparam logic [7:0] SEG_SEVEN = 8'hE0;
    localparam logic [7:0] SEG_EIGHT = 8'hFE;
    localparam logic [7:0] SEG_NINE  = 8'hF6;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot timing for the scan driver: BLANK/DRIVE phases within each digit slot,
// digit index rotation and the end-of-frame pulse.
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int unsigned NUMDIGITS    = 4,
    parameter int unsigned REFRESH_DIV  = 1000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    output logic [idx_width(NUMDIGITS)-1:0]      idx_next_o,
    output logic                                 drive_next_o,
    output logic                                 slot_end_o,
    output logic                                 frame_tick_o
);

    localparam int unsigned IDXW = idx_width(NUMDIGITS);
    localparam int unsigned CNTW = $clog2(REFRESH_DIV);

    scan_state_t     state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            slot_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // slot_cnt runs across the whole slot; the phase boundary is a compare point
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNTW'(1);
        idx_d    = idx_q;
        slot_end = 1'b0;
        case (state_q)
            BLANK: begin
                if (cnt_q == CNTW'(BLANK_CYCLES - 1)) state_d = DRIVE;
            end
            DRIVE: begin
                if (cnt_q == CNTW'(REFRESH_DIV - 1)) begin
                    state_d  = BLANK;
                    cnt_d    = '0;
                    slot_end = 1'b1;
                    idx_d    = (idx_q == IDXW'(NUMDIGITS - 1)) ? '0 : idx_q + IDXW'(1);
                end
            end
            default: state_d = BLANK;
        endcase
    end

    assign idx_next_o   = idx_d;
    assign drive_next_o = (state_d == DRIVE);
    assign slot_end_o   = slot_end;
    assign frame_tick_o = slot_end && (idx_q == IDXW'(NUMDIGITS - 1));

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode 7-segment scan driver: frame-aligned BCD snapshot,
// leading-zero blanking and registered anode/segment outputs around an external decoder.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned NUMDIGITS     = 4,
    parameter int unsigned REFRESH_DIV   = 1000,
    parameter int unsigned BLANK_CYCLES  = 16,
    parameter bit          AN_ACTIVE_LOW = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4*NUMDIGITS-1:0] digits_in,
    input  logic                   load,
    input  logic                   lzb_en,
    input  logic [7:0]             seg_in,
    output logic [3:0]             digit,
    output logic [NUMDIGITS-1:0]   an,
    output logic [7:0]             seg_out,
    output logic                   frame_tick
);

    localparam int unsigned IDXW = idx_width(NUMDIGITS);

    logic [IDXW-1:0] idx_next;
    logic            drive_next;
    logic            slot_end;

    seg_scan_timer #(
        .NUMDIGITS    (NUMDIGITS),
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .idx_next_o   (idx_next),
        .drive_next_o (drive_next),
        .slot_end_o   (slot_end),
        .frame_tick_o (frame_tick)
    );

    logic [4*NUMDIGITS-1:0] shadow_q, shadow_d, display_q, display_d;
    logic                   pending_q, pending_d;
    logic [3:0]             digit_q, digit_sel;
    logic                   blank_q, blank_d, upper_nz;
    logic [NUMDIGITS-1:0]   an_q, an_d;
    logic [7:0]             seg_q, seg_d;

    // A load on the wrap cycle bypasses the shadow so it is not a frame late
    always_comb begin
        shadow_d  = shadow_q;
        display_d = display_q;
        pending_d = pending_q;
        if (frame_tick) begin
            if (load) display_d = digits_in;
            else if (pending_q) display_d = shadow_q;
            pending_d = 1'b0;
        end else if (load) begin
            pending_d = 1'b1;
        end
        if (load) shadow_d = digits_in;
    end

    // Next slot's digit and blank decision come from the post-wrap snapshot
    always_comb begin
        digit_sel = '0;
        upper_nz  = 1'b0;
        for (int unsigned i = 0; i < NUMDIGITS; i++) begin
            if (i == 32'(idx_next)) digit_sel = display_d[4*i +: 4];
            if (i >= 32'(idx_next) && display_d[4*i +: 4] != 4'd0) upper_nz = 1'b1;
        end
        blank_d = lzb_en && (idx_next != '0) && !upper_nz;
    end

    always_comb begin
        an_d  = '0;
        seg_d = SEG_BLANK;
        if (drive_next && !blank_q) begin
            for (int unsigned i = 0; i < NUMDIGITS; i++) an_d[i] = (i == 32'(idx_next));
            seg_d = seg_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q  <= '0;
            display_q <= '0;
            pending_q <= 1'b0;
            digit_q   <= '0;
            blank_q   <= 1'b0;
            an_q      <= '0;
            seg_q     <= SEG_BLANK;
        end else begin
            shadow_q  <= shadow_d;
            display_q <= display_d;
            pending_q <= pending_d;
            if (slot_end) begin
                digit_q <= digit_sel;
                blank_q <= blank_d;
            end
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign digit   = digit_q;
    assign an      = AN_ACTIVE_LOW ? ~an_q : an_q;
    assign seg_out = seg_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver with an attached BCD-to-7-segment decoder.
module tb_seg_scan_driver;

    localparam int unsigned SLOT  = 8;
    localparam int unsigned FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits_in;
    logic        load;
    logic        lzb_en;
    logic [7:0]  seg_in;
    logic [3:0]  digit;
    logic [3:0]  an;
    logic [7:0]  seg_out;
    logic        frame_tick;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc;

    seg_scan_driver #(
        .NUMDIGITS     (4),
        .REFRESH_DIV   (8),
        .BLANK_CYCLES  (2),
        .AN_ACTIVE_LOW (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits_in  (digits_in),
        .load       (load),
        .lzb_en     (lzb_en),
        .seg_in     (seg_in),
        .digit      (digit),
        .an         (an),
        .seg_out    (seg_out),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 8'hFC;
            4'd1: return 8'h60;
            4'd2: return 8'hDA;
            4'd3: return 8'hF2;
            4'd4: return 8'h66;
            4'd5: return 8'hB6;
            4'd6: return 8'hBE;
            4'd7: return 8'hE0;
            4'd8: return 8'hFE;
            4'd9: return 8'hF6;
            default: return 8'h01;
        endcase
    endfunction

    assign seg_in = seg_of(digit);

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Model: a frame shows the last value loaded before it began; lzb_en is taken
    // from the final clock of the preceding slot.
    logic [15:0] latest, shown;
    bit          slot_lzb, lzb_last;
    int unsigned m_pos, m_idx;
    logic [3:0]  m_d;
    bit          m_blank;
    logic [3:0]  exp_an;
    logic [7:0]  exp_seg;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_an", 32'(an), 32'h0);
            chk("rst_seg", 32'(seg_out), 32'h0);
            chk("rst_tick", 32'(frame_tick), 32'h0);
            chk("rst_digit", 32'(digit), 32'h0);
            latest   = '0;
            shown    = '0;
            slot_lzb = 1'b0;
            lzb_last = 1'b0;
        end else begin
            if (cyc % FRAME == 0) shown = latest;
            if (cyc % SLOT == 0)  slot_lzb = lzb_last;
            m_pos   = cyc % SLOT;
            m_idx   = (cyc / SLOT) % 4;
            m_d     = 4'(shown >> (4 * m_idx));
            m_blank = slot_lzb && (m_idx != 0) && ((shown >> (4 * m_idx)) == 16'h0);
            exp_an  = (m_pos >= 2 && !m_blank) ? 4'(1 << m_idx) : 4'h0;
            exp_seg = (m_pos >= 2 && !m_blank) ? seg_of(m_d) : 8'h00;
            chk("model_an", 32'(an), 32'(exp_an));
            chk("model_seg", 32'(seg_out), 32'(exp_seg));
            chk("model_digit", 32'(digit), 32'(m_d));
            chk("model_tick", 32'(frame_tick), 32'(cyc % FRAME == FRAME - 1));
            if (load) latest = digits_in;
            lzb_last = lzb_en;
        end
    end

    task automatic wait_cyc(input int unsigned t);
        @(negedge clk);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic expect_at(input int unsigned t, input logic [3:0] a, input logic [7:0] s);
        wait_cyc(t);
        chk("lit_an", 32'(an), 32'(a));
        chk("lit_seg", 32'(seg_out), 32'(s));
    endtask

    task automatic load_at(input int unsigned t, input logic [15:0] v);
        wait_cyc(t - 1);
        @(posedge clk);
        #1 digits_in = v;
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    task automatic lzb_at(input int unsigned t, input bit v);
        wait_cyc(t - 1);
        @(posedge clk);
        #1 lzb_en = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        rst       = 1'b1;
        load      = 1'b0;
        lzb_en    = 1'b0;
        digits_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        expect_at(0, 4'b0000, 8'h00);
        expect_at(1, 4'b0000, 8'h00);
        expect_at(2, 4'b0001, 8'hFC);
        load_at(5, 16'h1234);
        wait_cyc(31);
        chk("lit_tick31", 32'(frame_tick), 32'h1);
        expect_at(34, 4'b0001, 8'h66);
        expect_at(42, 4'b0010, 8'hF2);
        load_at(45, 16'h5555);
        expect_at(50, 4'b0100, 8'hDA);
        expect_at(58, 4'b1000, 8'h60);
        wait_cyc(62);
        chk("lit_tick62", 32'(frame_tick), 32'h0);
        expect_at(66, 4'b0001, 8'hB6);
        lzb_at(90, 1'b1);
        load_at(95, 16'h0070);
        expect_at(98, 4'b0001, 8'hFC);
        load_at(100, 16'h0000);
        expect_at(106, 4'b0010, 8'hE0);
        expect_at(114, 4'b0000, 8'h00);
        expect_at(122, 4'b0000, 8'h00);
        expect_at(130, 4'b0001, 8'hFC);
        expect_at(138, 4'b0000, 8'h00);
        load_at(140, 16'h000A);
        expect_at(146, 4'b0000, 8'h00);
        expect_at(154, 4'b0000, 8'h00);
        lzb_at(156, 1'b0);
        expect_at(162, 4'b0001, 8'h01);
        load_at(165, 16'h1111);
        expect_at(170, 4'b0010, 8'hFC);
        expect_at(178, 4'b0100, 8'hFC);
        load_at(180, 16'h2222);
        expect_at(186, 4'b1000, 8'hFC);
        expect_at(194, 4'b0001, 8'hDA);
        expect_at(202, 4'b0010, 8'hDA);

        wait_cyc(204);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_an", 32'(an), 32'h0);
        chk("async_rst_seg", 32'(seg_out), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        expect_at(0, 4'b0000, 8'h00);
        expect_at(1, 4'b0000, 8'h00);
        expect_at(2, 4'b0001, 8'hFC);
        n = 0;
        while (!frame_tick && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("tick_seen", 32'(frame_tick), 32'h1);
        chk("tick_cycle", cyc, 32'd31);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
